// File: rtl/dm_sba_arbiter.sv
// dm_sba_arbiter: round-robin arbiter sharing the debug-module system-bus master port
module dm_sba_arbiter #(
    parameter int          NR_REQ         = 2,
    parameter int          ADDR_WIDTH     = 64,
    parameter int          DATA_WIDTH     = 64,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [63:0] ERR_RDATA      = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NR_REQ-1:0]              s_req_i,
    input  logic [NR_REQ-1:0]              s_we_i,
    input  logic [NR_REQ*ADDR_WIDTH-1:0]   s_addr_i,
    input  logic [NR_REQ*DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [NR_REQ*DATA_WIDTH/8-1:0] s_be_i,
    output logic [NR_REQ-1:0]              s_gnt_o,
    output logic [NR_REQ-1:0]              s_r_valid_o,
    output logic [DATA_WIDTH-1:0]          s_r_rdata_o,
    output logic                           m_req_o,
    output logic                           m_we_o,
    output logic [ADDR_WIDTH-1:0]          m_addr_o,
    output logic [DATA_WIDTH-1:0]          m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        m_be_o,
    input  logic                           m_gnt_i,
    input  logic                           m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          m_r_rdata_i,
    output logic [$clog2(NR_REQ)-1:0]      owner_o,
    output logic                           busy_o,
    output logic                           timeout_o
);
    localparam int OW = $clog2(NR_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] RSP   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state, state_d;
    logic [OW-1:0] owner, rr, pick, owner_nx;
    logic [CW-1:0] cnt;
    logic          in_req, fire, rsp, tmo;

    // first requester at or after ptr, wrapping; downward scan leaves the nearest one
    function automatic logic [OW-1:0] rr_pick(input logic [NR_REQ-1:0] req, input logic [OW-1:0] ptr);
        int idx;
        rr_pick = ptr;
        for (int k = NR_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NR_REQ;
            if (req[idx]) rr_pick = OW'(idx);
        end
    endfunction

    // transaction control: owner drop aborts REQ, response or expiry ends RSP
    always_comb begin
        pick     = rr_pick(s_req_i, rr);
        in_req   = (state == REQ) && s_req_i[owner];
        fire     = in_req && m_gnt_i;
        rsp      = (state == RSP) && m_r_valid_i;
        tmo      = (state == RSP) && !m_r_valid_i && (cnt == CW'(TIMEOUT_CYCLES - 1));
        owner_nx = (owner == OW'(NR_REQ - 1)) ? '0 : owner + OW'(1);
        state_d  = (state == IDLE) ? ((|s_req_i) ? REQ : IDLE)
                 : (state == REQ)  ? (!s_req_i[owner] ? IDLE : m_gnt_i ? RSP : REQ)
                 : (state == RSP)  ? (m_r_valid_i ? IDLE : tmo ? DRAIN : RSP)
                 : (m_r_valid_i ? IDLE : DRAIN);
    end

    assign m_req_o     = in_req;
    assign m_we_o      = in_req && s_we_i[owner];
    assign m_addr_o    = in_req ? s_addr_i[owner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign m_wdata_o   = in_req ? s_wdata_i[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_be_o      = in_req ? s_be_i[owner*BW +: BW] : '0;
    assign s_gnt_o     = fire ? (NR_REQ'(1) << owner) : '0;
    assign s_r_valid_o = (rsp || tmo) ? (NR_REQ'(1) << owner) : '0;
    assign s_r_rdata_o = rsp ? m_r_rdata_i : tmo ? DATA_WIDTH'(ERR_RDATA) : '0;
    assign owner_o     = owner;
    assign busy_o      = state != IDLE;
    assign timeout_o   = tmo;

    // state, owner, round-robin pointer and response-wait counter
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            owner <= '0;
            rr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && |s_req_i) owner <= pick;
            if (rsp || tmo) rr <= owner_nx;
            cnt <= fire ? '0 : (state == RSP) ? cnt + CW'(1) : cnt;
        end
    end
endmodule

// File: tb/tb_dm_sba_arbiter.sv
// tb_dm_sba_arbiter: directed checks of arbitration order, responses, timeout/drain and reset
module tb_dm_sba_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [1:0]    s_req = '0, s_we = '0;
    logic [2*AW-1:0] s_addr;
    logic [2*DW-1:0] s_wdata;
    logic [2*DW/8-1:0] s_be;
    logic [1:0]    s_gnt, s_r_valid;
    logic [DW-1:0] s_r_rdata;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW/8-1:0] m_be;
    logic          m_gnt = 1'b0, m_r_valid = 1'b0;
    logic [DW-1:0] m_r_rdata = '0;
    logic [0:0]    owner;
    logic          busy, timeout;
    int            total = 0, bad = 0;

    logic [AW-1:0] addr0 = 32'h8000_0000, addr1 = 32'h9000_0010;
    assign s_addr  = {addr1, addr0};
    assign s_wdata = {32'h1111_2222, 32'h3333_4444};
    assign s_be    = {4'hC, 4'h3};

    dm_sba_arbiter #(.NR_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_i(s_req), .s_we_i(s_we), .s_addr_i(s_addr), .s_wdata_i(s_wdata), .s_be_i(s_be),
        .s_gnt_o(s_gnt), .s_r_valid_o(s_r_valid), .s_r_rdata_o(s_r_rdata),
        .m_req_o(m_req), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_be_o(m_be),
        .m_gnt_i(m_gnt), .m_r_valid_i(m_r_valid), .m_r_rdata_i(m_r_rdata),
        .owner_o(owner), .busy_o(busy), .timeout_o(timeout)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #2;
    endtask

    // one full transaction from IDLE: arbitration, grant, response two RSP cycles later
    task automatic serve(input logic [1:0] req, input int exp, input logic [DW-1:0] rd);
        s_req = req;
        #1;
        chk("idle_no_req", m_req, 0);
        cyc();
        m_gnt = 1'b1;
        #1;
        chk("owner", owner, exp);
        chk("gnt", s_gnt, 2'b01 << exp);
        chk("m_addr", m_addr, exp == 0 ? addr0 : addr1);
        cyc();
        m_gnt = 1'b0;
        cyc();
        m_r_valid = 1'b1;
        m_r_rdata = rd;
        #1;
        chk("r_valid", s_r_valid, 2'b01 << exp);
        chk("r_rdata", s_r_rdata, rd);
        cyc();
        m_r_valid = 1'b0;
        #1;
        chk("busy_after_rsp", busy, 0);
    endtask

    initial begin
        #3;
        chk("rst_gnt", s_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_addr", m_addr, 0);
        @(posedge aclk);
        #2;
        aresetn = 1'b1;

        // single read from requester 0, response three cycles after the grant
        s_req = 2'b01;
        #1;
        chk("t1_idle_m_req", m_req, 0);
        cyc();
        m_gnt = 1'b1;
        #1;
        chk("t1_gnt", s_gnt, 2'b01);
        chk("t1_m_req", m_req, 1);
        chk("t1_m_addr", m_addr, 32'h8000_0000);
        chk("t1_m_be", m_be, 4'h3);
        cyc();
        m_gnt = 1'b0;
        s_req = 2'b00;
        #1;
        chk("t1_rsp_m_req", m_req, 0);
        chk("t1_rsp_idle_out", s_r_valid, 0);
        cyc();
        cyc();
        m_r_valid = 1'b1;
        m_r_rdata = 32'h1234;
        #1;
        chk("t1_r_valid", s_r_valid, 2'b01);
        chk("t1_rdata", s_r_rdata, 32'h1234);
        chk("t1_owner", owner, 0);
        cyc();
        m_r_valid = 1'b0;
        #1;
        chk("t1_idle", busy, 0);
        chk("t1_rdata_zero", s_r_rdata, 0);

        // rr=1 with only requester 0 asking, then 1 joins and wins
        serve(2'b01, 0, 32'hA000_0001);
        serve(2'b11, 1, 32'hA000_0002);
        // continuous contention from rr=0: 0,1,0,1
        serve(2'b11, 0, 32'hA000_0003);
        serve(2'b11, 1, 32'hA000_0004);
        serve(2'b11, 0, 32'hA000_0005);
        serve(2'b11, 1, 32'hA000_0006);

        // timeout on requester 0 after 8 RSP cycles, then drain of a late response
        s_req = 2'b01;
        cyc();
        m_gnt = 1'b1;
        #1;
        chk("to_gnt", s_gnt, 2'b01);
        cyc();
        m_gnt = 1'b0;
        s_req = 2'b00;
        for (int i = 1; i < 7; i++) cyc();
        #1;
        chk("to_not_yet", timeout, 0);
        cyc();
        #1;
        chk("to_pulse", timeout, 1);
        chk("to_r_valid", s_r_valid, 2'b01);
        chk("to_rdata", s_r_rdata, 32'hDEAD_BEEF);
        cyc();
        #1;
        chk("to_pulse_end", timeout, 0);
        chk("drain_busy", busy, 1);
        for (int i = 0; i < 4; i++) cyc();
        s_req = 2'b10;
        m_r_valid = 1'b1;
        m_r_rdata = 32'h5555;
        #1;
        chk("drain_swallow", s_r_valid, 0);
        chk("drain_rdata", s_r_rdata, 0);
        chk("drain_no_req", m_req, 0);
        cyc();
        m_r_valid = 1'b0;
        #1;
        chk("drain_done", busy, 0);

        // requester 1 arbitrated, then drops before grant
        cyc();
        s_req = 2'b01;
        #1;
        chk("drop_owner", owner, 1);
        chk("drop_m_req", m_req, 0);
        chk("drop_gnt", s_gnt, 0);
        cyc();
        #1;
        chk("drop_idle", busy, 0);
        serve(2'b11, 1, 32'hA000_0007);
        serve(2'b01, 0, 32'hA000_0008);

        // asynchronous reset while waiting for a response
        s_req = 2'b01;
        cyc();
        m_gnt = 1'b1;
        cyc();
        m_gnt = 1'b0;
        #1;
        chk("pre_rst_busy", busy, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_m_req", m_req, 0);
        chk("arst_owner", owner, 0);
        s_req = 2'b00;
        cyc();
        aresetn = 1'b1;
        m_r_valid = 1'b1;
        m_r_rdata = 32'h7777;
        #1;
        chk("stray_r_valid", s_r_valid, 0);
        cyc();
        m_r_valid = 1'b0;
        serve(2'b11, 0, 32'hA000_0009);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
